// File: rtl/conv_mc_compute_actv_pkg.sv
// Shared types and helpers for the multi-filter conv compute + activation slice.
package conv_pkg;

  // Run-time activation selector, latched on the first row beat of a frame.
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP6 = 2'd3
  } act_mode_e;

  // Frame sequencing: accumulate rows, activate once, hold until consumed.
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    ACTV  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Accumulator width large enough that a full kernel sum can never wrap.
  function automatic int acc_width(input int pixel_w, input int weight_w,
                                   input int rows, input int cols);
    return pixel_w + weight_w + 1 + $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/conv_mc_compute_actv_actv_quant.sv
// Per-element activation, arithmetic right shift and saturation to the output width.
module actv_quant
  import conv_pkg::*;
#(
  parameter int ACC_WIDTH = 22,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 4
) (
  input  logic [1:0]           mode,
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] y
);

  localparam logic signed [ACC_WIDTH-1:0] CLIP_HI = ACC_WIDTH'(6 << OUT_SHIFT);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic signed [ACC_WIDTH-1:0] activate(
    input act_mode_e m, input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] r;
    r = a;
    case (m)
      ACT_NONE:  r = a;
      ACT_RELU:  r = a[ACC_WIDTH-1] ? '0 : a;
      ACT_LEAKY: r = a[ACC_WIDTH-1] ? (a >>> 3) : a;
      ACT_CLIP6: r = a[ACC_WIDTH-1] ? '0 : ((a > CLIP_HI) ? CLIP_HI : a);
      default:   r = a;
    endcase
    return r;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    logic [OUT_WIDTH-1:0] r;
    if (v > SAT_HI)      r = SAT_HI[OUT_WIDTH-1:0];
    else if (v < SAT_LO) r = SAT_LO[OUT_WIDTH-1:0];
    else                 r = v[OUT_WIDTH-1:0];
    return r;
  endfunction

  logic signed [ACC_WIDTH-1:0] act_val;
  logic signed [ACC_WIDTH-1:0] shifted;

  // Activation, then scale down, then clamp into the signed output range.
  always_comb begin
    act_val = activate(act_mode_e'(mode), $signed(acc));
    shifted = act_val >>> OUT_SHIFT;
    y       = saturate(shifted);
  end

endmodule

// File: rtl/conv_mc_compute_actv.sv
// Row-streamed multi-filter conv slice: accumulates FILTER_ROWS row beats into
// NUM_FILTERS x NUM_OUTPUTS strided dot products, then activates, shifts,
// saturates and presents one registered result per frame.
module conv_mc_compute_actv
  import conv_pkg::*;
#(
  parameter int NUM_FILTERS  = 4,
  parameter int NUM_OUTPUTS  = 4,
  parameter int STRIDE       = 1,
  parameter int FILTER_ROWS  = 5,
  parameter int FILTER_COLS  = 5,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUT_WIDTH    = 16,
  parameter int OUT_SHIFT    = 4,
  parameter int IN_COLS      = (NUM_OUTPUTS - 1) * STRIDE + FILTER_COLS,
  parameter int ACC_WIDTH    = acc_width(PIXEL_WIDTH, WEIGHT_WIDTH, FILTER_ROWS, FILTER_COLS)
) (
  input  logic                                   conv_actv_clk,
  input  logic                                   conv_actv_rst,
  input  logic                                   conv_flush_i,
  input  logic [1:0]                             conv_act_mode_i,
  input  logic [IN_COLS-1:0][PIXEL_WIDTH-1:0]    conv_row_i,
  input  logic                                   conv_row_valid_i,
  output logic                                   conv_row_ready_o,
  input  logic [NUM_FILTERS-1:0][FILTER_ROWS-1:0][FILTER_COLS-1:0][WEIGHT_WIDTH-1:0] conv_weights_i,
  output logic [NUM_FILTERS-1:0][NUM_OUTPUTS-1:0][OUT_WIDTH-1:0] conv_out_o,
  output logic                                   conv_out_valid_o,
  input  logic                                   conv_out_ready_i
);

  localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH + 1;
  localparam int RCW    = (FILTER_ROWS > 1) ? $clog2(FILTER_ROWS) : 1;
  localparam logic [RCW-1:0] LAST_ROW = RCW'(FILTER_ROWS - 1);

  state_e                      state;
  logic [RCW-1:0]              row_cnt;
  act_mode_e                   act_mode_p0;
  logic signed [PROD_W-1:0]    prod    [NUM_FILTERS][NUM_OUTPUTS][FILTER_COLS];
  logic signed [ACC_WIDTH-1:0] partial [NUM_FILTERS][NUM_OUTPUTS];
  logic signed [ACC_WIDTH-1:0] acc_p0  [NUM_FILTERS][NUM_OUTPUTS];
  logic [NUM_FILTERS-1:0][NUM_OUTPUTS-1:0][OUT_WIDTH-1:0] act_y;

  assign conv_row_ready_o = (state == ACCUM) && !conv_flush_i;

  // ---- Stage 0: per-row MAC array (zero-extended pixel x signed weight) ----
  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_f
    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_o
      for (genvar c = 0; c < FILTER_COLS; c++) begin : g_c
        assign prod[f][o][c] = $signed({1'b0, conv_row_i[o*STRIDE+c]})
                             * $signed(conv_weights_i[f][row_cnt][c]);
      end
    end
  end

  // Reduce each window's products for the current row into a full-width partial sum.
  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        partial[f][o] = '0;
        for (int c = 0; c < FILTER_COLS; c++) begin
          partial[f][o] = partial[f][o] + ACC_WIDTH'(prod[f][o][c]);
        end
      end
    end
  end

  // ---- Stage 1: activation + quantisation of the accumulated frame ----
  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_aq_f
    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_aq_o
      actv_quant #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
      ) u_actv_quant (
        .mode (act_mode_p0),
        .acc  (acc_p0[f][o]),
        .y    (act_y[f][o])
      );
    end
  end

  // Frame FSM: accumulate rows, register the activated result, hold until consumed.
  always_ff @(posedge conv_actv_clk) begin
    if (conv_actv_rst) begin
      state            <= ACCUM;
      row_cnt          <= '0;
      act_mode_p0      <= ACT_NONE;
      conv_out_o       <= '0;
      conv_out_valid_o <= 1'b0;
      for (int f = 0; f < NUM_FILTERS; f++) begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
          acc_p0[f][o] <= '0;
        end
      end
    end else begin
      case (state)
        ACCUM: begin
          if (conv_flush_i) begin
            // Restart the frame; the stale acc is overwritten by the next row 0.
            row_cnt <= '0;
          end else if (conv_row_valid_i) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
              for (int o = 0; o < NUM_OUTPUTS; o++) begin
                acc_p0[f][o] <= (row_cnt == '0) ? partial[f][o]
                                                : acc_p0[f][o] + partial[f][o];
              end
            end
            if (row_cnt == '0) act_mode_p0 <= act_mode_e'(conv_act_mode_i);
            if (row_cnt == LAST_ROW) begin
              row_cnt <= '0;
              state   <= ACTV;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        // ---- Stage 2: output register ----
        ACTV: begin
          conv_out_o       <= act_y;
          conv_out_valid_o <= 1'b1;
          state            <= HOLD;
        end
        HOLD: begin
          if (conv_out_ready_i) begin
            conv_out_valid_o <= 1'b0;
            state            <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
